dbg_trace_arbiter: RTL and testbench
====================================

Name: dbg_trace_arbiter

Overview:
- Sits directly upstream of the simulation monitor; collects per-hart debug trace events and serialises them onto the single monitor interface.
- Each hart has its own small FIFO. A round-robin arbiter drains at most one record per cycle into a registered output stage.
- Trace loss is explicit: cores are never stalled, and a record that arrives at a full FIFO is dropped and counted.

Parameters:
- N_HARTS, 2, number of harts traced; the output hart id is 1 bit, so the legal range is 1..2.
- DEPTH, 4, entries per hart FIFO; must be a power of 2 and at least 2.
- CNT_W, 16, width of each per-hart saturating drop counter.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- hart_valid  in  N_HARTS  per-hart trace event strobe.
- hart_fetch_ack  in  N_HARTS  fetch handshake completed this cycle.
- hart_fetch_addr  in  N_HARTS*32  fetch address, packed with hart 0 in the LSBs.
- hart_reg_wren  in  N_HARTS  register write-back occurred.
- hart_reg_wraddr  in  N_HARTS*5  write-back register index.
- hart_reg_wrdata  in  N_HARTS*64  write-back data.
- dbg_valid  out  1  output record valid.
- dbg_hart_id  out  1  source hart of the record.
- dbg_inst_fetch_req  out  1  equals the record's fetch_ack bit.
- dbg_inst_fetch_ack  out  1  equals the record's fetch_ack bit.
- dbg_inst_fetch_addr  out  32  record fetch address.
- dbg_reg_wren  out  1  record write enable.
- dbg_reg_wraddr  out  5  record register index.
- dbg_reg_wrdata  out  64  record write data.
- drop_cnt  out  N_HARTS*CNT_W  per-hart count of dropped records.
- overflow  out  N_HARTS  sticky per-hart flag, set on the first drop.

Behaviour:
- Record format: {fetch_ack, fetch_addr[31:0], reg_wren, reg_wraddr[4:0], reg_wrdata[63:0]}, 103 bits.
- Reset: all synchronous, applied on the clock edge while reset=1.
  - FIFO pointers and counts clear to 0.
  - Round-robin pointer clears to 0.
  - All outputs clear to 0, including drop_cnt and overflow.
  - Any in-flight record, buffered or in the output stage, is discarded.
- Push:
  - At each edge where hart_valid[h]=1, the record is written to FIFO h if it is not full.
  - If FIFO h is full and is also popped at the same edge, the push is accepted (pop-before-push).
  - If FIFO h is full and not popped, the record is dropped: drop_cnt[h] increments and saturates at 2^CNT_W-1, and overflow[h] is set.
- Arbitration (combinational, from current FIFO state):
  - Candidates are the non-empty FIFOs.
  - The search starts at the RR pointer; the first non-empty hart in ascending wrap-around order wins.
  - On a grant, the RR pointer becomes (winner+1) mod N_HARTS. With no grant, the pointer holds.
- Output stage:
  - At each edge, if a grant exists, the winner's head record is popped and loaded into the output register with dbg_valid=1 and dbg_hart_id=winner.
  - Otherwise dbg_valid=0 and the data fields hold their previous values.
  - There is no backpressure from the monitor; throughput is 1 record per cycle in aggregate.
- Latency: an event presented in cycle t (captured at edge t) appears on the outputs in cycle t+2 when uncontended, since the FIFO becomes non-empty in cycle t+1 and is popped at edge t+1.
- Ordering: records from one hart leave in arrival order. Interleaving between harts is determined only by the RR pointer.
- Empty FIFO with a simultaneous push: no bypass; the record waits one cycle, as in the latency rule.
- Pointer wrap: read and write pointers are log2(DEPTH) bits and wrap naturally. Full/empty is decided by a separate count of log2(DEPTH)+1 bits.
- N_HARTS=1: the arbiter degenerates to a single FIFO and dbg_hart_id is tied to 0.

Decomposition:
- Shared package dbg_trace_pkg holds:
  - the trace_rec_t packed struct defining the 103-bit record;
  - constant TRACE_REC_W=103;
  - the field offset constants.
- One sub-module, dbg_trace_fifo: a single-clock FIFO parameterised by DEPTH and width.
  - Ports: push, pop, din, dout, full, empty.
  - Supports simultaneous push and pop when full.
  - Instantiated N_HARTS times.
- Arbiter and output register stay in the top module.

Test Plan:
- Single event: hart0 valid at cycle 5 with fetch_ack=1, addr=0x80000000, wren=1, rd=3, data=0x1234 -> at cycle 7 dbg_valid=1, hart_id=0 with the same fields; dbg_valid=0 at cycle 8.
- Contention: both harts valid every cycle for 4 cycles with RR pointer=0 -> output hart ids alternate 0,1,0,1,... in a gap-free stream of 8 records, and per-hart order is preserved.
- Overflow: hart1 valid every cycle for 10 cycles while hart0 also streams, DEPTH=4 -> drop_cnt[1]>0 and overflow[1]=1; every record that emerges for hart1 is in increasing order with no duplicates.
- Full with simultaneous pop: hart0 FIFO holds 4 entries, hart1 idle, hart0 pushes every cycle -> no drops, drop_cnt[0]=0, one record out per cycle.
- Reset mid-operation: assert reset for 1 cycle while both FIFOs are half full and dbg_valid=1 -> the next cycle shows dbg_valid=0, drop_cnt=0, overflow=0, and no pre-reset record is ever emitted.
- Saturation: CNT_W=2 with 6 forced drops on hart0 -> drop_cnt[0] holds at 3.

Source files
------------

// File: rtl/dbg_trace_pkg.sv
// Shared trace record layout for the debug trace arbiter and its per-hart FIFOs.
// Field order is fixed by the monitor: fetch_ack at the MSB, write-back data at the LSBs.
package dbg_trace_pkg;

    localparam int TRACE_REC_W   = 103;

    localparam int WRDATA_LSB    = 0;
    localparam int WRDATA_W      = 64;
    localparam int WRADDR_LSB    = 64;
    localparam int WRADDR_W      = 5;
    localparam int WREN_BIT      = 69;
    localparam int FETCH_ADDR_LSB = 70;
    localparam int FETCH_ADDR_W  = 32;
    localparam int FETCH_ACK_BIT = 102;

    typedef struct packed {
        logic        fetch_ack;
        logic [31:0] fetch_addr;
        logic        reg_wren;
        logic [4:0]  reg_wraddr;
        logic [63:0] reg_wrdata;
    } trace_rec_t;

    function automatic trace_rec_t make_rec(
        input logic        fetch_ack,
        input logic [31:0] fetch_addr,
        input logic        reg_wren,
        input logic [4:0]  reg_wraddr,
        input logic [63:0] reg_wrdata
    );
        trace_rec_t rec;
        rec.fetch_ack  = fetch_ack;
        rec.fetch_addr = fetch_addr;
        rec.reg_wren   = reg_wren;
        rec.reg_wraddr = reg_wraddr;
        rec.reg_wrdata = reg_wrdata;
        return rec;
    endfunction

endpackage

// File: rtl/dbg_trace_fifo.sv
// Single-clock circular FIFO for one hart's trace records.
// A pop frees the slot that a push may reuse at the same edge, so a full FIFO still accepts.
module dbg_trace_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 103
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   COUNT_ZERO = {(PTR_W + 1){1'b0}};
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO   = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (count_r == COUNT_ZERO);
    assign full      = (count_r == FULL_COUNT);
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign dout      = mem_r[rd_ptr_r];

    // Pointer and occupancy tracking; pointers wrap naturally, count decides full/empty
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
            count_r  <= COUNT_ZERO;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + COUNT_ONE;
                2'b01:   count_r <= count_r - COUNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array carries no reset; entry validity is tracked by count_r alone
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/dbg_trace_arbiter.sv
// Collects per-hart trace events into per-hart FIFOs and serialises them onto the monitor
// interface through a round-robin arbiter and a registered output stage. Cores never stall.
module dbg_trace_arbiter
    import dbg_trace_pkg::*;
#(
    parameter int N_HARTS = 2,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_HARTS-1:0]         hart_valid,
    input  logic [N_HARTS-1:0]         hart_fetch_ack,
    input  logic [N_HARTS*32-1:0]      hart_fetch_addr,
    input  logic [N_HARTS-1:0]         hart_reg_wren,
    input  logic [N_HARTS*5-1:0]       hart_reg_wraddr,
    input  logic [N_HARTS*64-1:0]      hart_reg_wrdata,
    output logic                       dbg_valid,
    output logic                       dbg_hart_id,
    output logic                       dbg_inst_fetch_req,
    output logic                       dbg_inst_fetch_ack,
    output logic [31:0]                dbg_inst_fetch_addr,
    output logic                       dbg_reg_wren,
    output logic [4:0]                 dbg_reg_wraddr,
    output logic [63:0]                dbg_reg_wrdata,
    output logic [N_HARTS*CNT_W-1:0]   drop_cnt,
    output logic [N_HARTS-1:0]         overflow
);

    // The hart id is one bit wide, so the arbiter is built for two slots;
    // slots beyond N_HARTS look permanently empty.
    localparam int MAX_HARTS = 2;

    trace_rec_t             head_s [MAX_HARTS];
    logic [MAX_HARTS-1:0]   empty_s;
    logic [MAX_HARTS-1:0]   pop_s;
    logic                   grant_s;
    logic                   winner_s;
    logic                   rr_next_s;
    logic                   rr_ptr_r;
    logic                   out_valid_r;
    logic                   out_hart_r;
    trace_rec_t             out_rec_r;
    logic [TRACE_REC_W-1:0] out_flat_s;

    for (genvar h = 0; h < MAX_HARTS; h++) begin : g_hart
        if (h < N_HARTS) begin : g_live
            trace_rec_t             rec_in_s;
            logic [TRACE_REC_W-1:0] head_flat_s;
            logic                   full_s;
            logic                   drop_s;
            logic [CNT_W-1:0]       cnt_r;
            logic                   ovf_r;

            assign rec_in_s = make_rec(hart_fetch_ack[h],
                                       hart_fetch_addr[h*32 +: 32],
                                       hart_reg_wren[h],
                                       hart_reg_wraddr[h*5 +: 5],
                                       hart_reg_wrdata[h*64 +: 64]);

            dbg_trace_fifo #(
                .DEPTH (DEPTH),
                .WIDTH (TRACE_REC_W)
            ) u_fifo (
                .clock (clock),
                .reset (reset),
                .push  (hart_valid[h]),
                .pop   (pop_s[h]),
                .din   (rec_in_s),
                .dout  (head_flat_s),
                .full  (full_s),
                .empty (empty_s[h])
            );

            assign head_s[h] = trace_rec_t'(head_flat_s);
            assign drop_s    = hart_valid[h] & full_s & ~pop_s[h];

            // Saturating drop counter and sticky overflow flag for this hart
            always_ff @(posedge clock) begin
                if (reset) begin
                    cnt_r <= {CNT_W{1'b0}};
                    ovf_r <= 1'b0;
                end else if (drop_s) begin
                    cnt_r <= (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + CNT_W'(1);
                    ovf_r <= 1'b1;
                end
            end

            assign drop_cnt[h*CNT_W +: CNT_W] = cnt_r;
            assign overflow[h]                = ovf_r;
        end else begin : g_absent
            assign empty_s[h] = 1'b1;
            assign head_s[h]  = trace_rec_t'({TRACE_REC_W{1'b0}});
        end
    end

    // Round-robin pick: the pointer's hart first, then the other slot
    always_comb begin
        grant_s  = 1'b0;
        winner_s = 1'b0;
        if (!empty_s[rr_ptr_r]) begin
            grant_s  = 1'b1;
            winner_s = rr_ptr_r;
        end else if (!empty_s[~rr_ptr_r]) begin
            grant_s  = 1'b1;
            winner_s = ~rr_ptr_r;
        end else begin
            grant_s  = 1'b0;
            winner_s = 1'b0;
        end
    end

    assign rr_next_s = (N_HARTS == 1) ? 1'b0 : ~winner_s;
    assign pop_s     = grant_s ? (MAX_HARTS'(1) << winner_s) : {MAX_HARTS{1'b0}};

    // Output stage: load the granted head record; data fields hold when idle
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_r    <= 1'b0;
            out_valid_r <= 1'b0;
            out_hart_r  <= 1'b0;
            out_rec_r   <= trace_rec_t'({TRACE_REC_W{1'b0}});
        end else begin
            out_valid_r <= grant_s;
            if (grant_s) begin
                rr_ptr_r   <= rr_next_s;
                out_hart_r <= winner_s;
                out_rec_r  <= head_s[winner_s];
            end
        end
    end

    assign out_flat_s          = out_rec_r;
    assign dbg_valid           = out_valid_r;
    assign dbg_hart_id         = (N_HARTS == 1) ? 1'b0 : out_hart_r;
    assign dbg_inst_fetch_ack  = out_flat_s[FETCH_ACK_BIT];
    assign dbg_inst_fetch_req  = out_flat_s[FETCH_ACK_BIT];
    assign dbg_inst_fetch_addr = out_flat_s[FETCH_ADDR_LSB +: FETCH_ADDR_W];
    assign dbg_reg_wren        = out_flat_s[WREN_BIT];
    assign dbg_reg_wraddr      = out_flat_s[WRADDR_LSB +: WRADDR_W];
    assign dbg_reg_wrdata      = out_flat_s[WRDATA_LSB +: WRDATA_W];

endmodule

// File: tb/tb_dbg_trace_arbiter.sv
// Directed-plus-random bench for dbg_trace_arbiter, checked against a queue-based reference model.
// A second instance with 2-bit drop counters shares the stimulus to exercise saturation.
module tb_dbg_trace_arbiter;

    localparam int NH    = 2;
    localparam int DEPTH = 4;

    logic          clock;
    logic          reset;
    logic [1:0]    hart_valid;
    logic [1:0]    hart_fetch_ack;
    logic [63:0]   hart_fetch_addr;
    logic [1:0]    hart_reg_wren;
    logic [9:0]    hart_reg_wraddr;
    logic [127:0]  hart_reg_wrdata;

    logic          dbg_valid, dbg_hart_id, dbg_inst_fetch_req, dbg_inst_fetch_ack;
    logic [31:0]   dbg_inst_fetch_addr;
    logic          dbg_reg_wren;
    logic [4:0]    dbg_reg_wraddr;
    logic [63:0]   dbg_reg_wrdata;
    logic [31:0]   drop_cnt;
    logic [1:0]    overflow;

    logic          s_valid, s_hart_id, s_fetch_req, s_fetch_ack;
    logic [31:0]   s_fetch_addr;
    logic          s_wren;
    logic [4:0]    s_wraddr;
    logic [63:0]   s_wrdata;
    logic [3:0]    s_drop_cnt;
    logic [1:0]    s_overflow;

    dbg_trace_arbiter #(.N_HARTS(NH), .DEPTH(DEPTH), .CNT_W(16)) u_dut (
        .clock(clock), .reset(reset), .hart_valid(hart_valid), .hart_fetch_ack(hart_fetch_ack),
        .hart_fetch_addr(hart_fetch_addr), .hart_reg_wren(hart_reg_wren),
        .hart_reg_wraddr(hart_reg_wraddr), .hart_reg_wrdata(hart_reg_wrdata),
        .dbg_valid(dbg_valid), .dbg_hart_id(dbg_hart_id), .dbg_inst_fetch_req(dbg_inst_fetch_req),
        .dbg_inst_fetch_ack(dbg_inst_fetch_ack), .dbg_inst_fetch_addr(dbg_inst_fetch_addr),
        .dbg_reg_wren(dbg_reg_wren), .dbg_reg_wraddr(dbg_reg_wraddr), .dbg_reg_wrdata(dbg_reg_wrdata),
        .drop_cnt(drop_cnt), .overflow(overflow)
    );

    dbg_trace_arbiter #(.N_HARTS(NH), .DEPTH(DEPTH), .CNT_W(2)) u_dut_sat (
        .clock(clock), .reset(reset), .hart_valid(hart_valid), .hart_fetch_ack(hart_fetch_ack),
        .hart_fetch_addr(hart_fetch_addr), .hart_reg_wren(hart_reg_wren),
        .hart_reg_wraddr(hart_reg_wraddr), .hart_reg_wrdata(hart_reg_wrdata),
        .dbg_valid(s_valid), .dbg_hart_id(s_hart_id), .dbg_inst_fetch_req(s_fetch_req),
        .dbg_inst_fetch_ack(s_fetch_ack), .dbg_inst_fetch_addr(s_fetch_addr),
        .dbg_reg_wren(s_wren), .dbg_reg_wraddr(s_wraddr), .dbg_reg_wrdata(s_wrdata),
        .drop_cnt(s_drop_cnt), .overflow(s_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state: one queue per hart plus the expected output register
    logic [102:0] q0[$];
    logic [102:0] q1[$];
    int           rr_m;
    logic         ev_m;
    int           eh_m;
    logic [102:0] er_m;
    int           drop_m [2];
    logic         ovf_m [2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int h);
        return (h == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int predict_winner();
        for (int k = 0; k < NH; k++) begin
            int h;
            h = (rr_m + k) % NH;
            if (qsize(h) > 0) return h;
        end
        return -1;
    endfunction

    function automatic logic safe_push(input int h);
        return (qsize(h) < DEPTH) || (predict_winner() == h);
    endfunction

    function automatic logic [102:0] cur_rec(input int h);
        return {hart_fetch_ack[h], hart_fetch_addr[h*32 +: 32], hart_reg_wren[h],
                hart_reg_wraddr[h*5 +: 5], hart_reg_wrdata[h*64 +: 64]};
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_edge();
        int w;
        if (reset) begin
            q0.delete();
            q1.delete();
            rr_m = 0; ev_m = 1'b0; eh_m = 0; er_m = '0;
            for (int h = 0; h < NH; h++) begin
                drop_m[h] = 0;
                ovf_m[h]  = 1'b0;
            end
        end else begin
            w = predict_winner();
            ev_m = (w >= 0);
            if (w == 0) er_m = q0.pop_front();
            if (w == 1) er_m = q1.pop_front();
            if (w >= 0) begin
                eh_m = w;
                rr_m = (w + 1) % NH;
            end
            for (int h = 0; h < NH; h++) begin
                if (hart_valid[h]) begin
                    if (qsize(h) < DEPTH) begin
                        if (h == 0) q0.push_back(cur_rec(0));
                        else        q1.push_back(cur_rec(1));
                    end else begin
                        drop_m[h]++;
                        ovf_m[h] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [102:0] obs_rec;
        obs_rec = {dbg_inst_fetch_ack, dbg_inst_fetch_addr, dbg_reg_wren, dbg_reg_wraddr, dbg_reg_wrdata};
        chk("valid", dbg_valid, ev_m);
        if (ev_m) chk("hart_id", dbg_hart_id, eh_m);
        chk("record", obs_rec, er_m);
        chk("fetch_req", dbg_inst_fetch_req, er_m[102]);
        chk("drop_cnt0", drop_cnt[15:0], sat(drop_m[0], 65535));
        chk("drop_cnt1", drop_cnt[31:16], sat(drop_m[1], 65535));
        chk("overflow", overflow, {ovf_m[1], ovf_m[0]});
        chk("sat_valid", s_valid, ev_m);
        chk("sat_drop_cnt0", s_drop_cnt[1:0], sat(drop_m[0], 3));
        chk("sat_drop_cnt1", s_drop_cnt[3:2], sat(drop_m[1], 3));
        chk("sat_overflow", s_overflow, {ovf_m[1], ovf_m[0]});
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check_outputs();
        cyc++;
    endtask

    task automatic set_rand(input int h);
        hart_fetch_ack[h]           = 1'($urandom);
        hart_fetch_addr[h*32 +: 32] = $urandom;
        hart_reg_wren[h]            = 1'($urandom);
        hart_reg_wraddr[h*5 +: 5]   = 5'($urandom);
        hart_reg_wrdata[h*64 +: 64] = {$urandom, $urandom};
    endtask

    initial begin
        int ids[$];
        int vcyc[$];

        reset = 1'b1;
        hart_valid = 2'b00; hart_fetch_ack = 2'b00; hart_fetch_addr = '0;
        hart_reg_wren = 2'b00; hart_reg_wraddr = '0; hart_reg_wrdata = '0;
        step();
        step();
        reset = 1'b0;
        chk("reset_valid", dbg_valid, 1'b0);
        chk("reset_drop", drop_cnt, 32'd0);
        repeat (3) step();

        // Single uncontended event: visible two edges after capture, for one cycle
        hart_valid = 2'b01;
        hart_fetch_ack[0] = 1'b1;
        hart_fetch_addr[31:0] = 32'h8000_0000;
        hart_reg_wren[0] = 1'b1;
        hart_reg_wraddr[4:0] = 5'd3;
        hart_reg_wrdata[63:0] = 64'h1234;
        step();
        hart_valid = 2'b00;
        chk("single_t0_valid", dbg_valid, 1'b0);
        step();
        chk("single_valid", dbg_valid, 1'b1);
        chk("single_hart", dbg_hart_id, 1'b0);
        chk("single_ack", dbg_inst_fetch_ack, 1'b1);
        chk("single_addr", dbg_inst_fetch_addr, 32'h8000_0000);
        chk("single_wren", dbg_reg_wren, 1'b1);
        chk("single_rd", dbg_reg_wraddr, 5'd3);
        chk("single_data", dbg_reg_wrdata, 64'h1234);
        step();
        chk("single_after", dbg_valid, 1'b0);

        // A hart1 event moves the RR pointer back to 0
        set_rand(1);
        hart_valid = 2'b10;
        step();
        hart_valid = 2'b00;
        repeat (3) step();

        // Contention: gap-free alternating stream of 8 records
        for (int k = 0; k < 10; k++) begin
            set_rand(0);
            set_rand(1);
            hart_valid = (k < 4) ? 2'b11 : 2'b00;
            step();
            if (dbg_valid) begin
                ids.push_back(int'(dbg_hart_id));
                vcyc.push_back(cyc);
            end
        end
        chk("cont_count", ids.size(), 8);
        for (int i = 0; i < ids.size(); i++) begin
            chk("cont_id", ids[i], i % 2);
            if (i > 0) chk("cont_gapfree", vcyc[i] - vcyc[i-1], 1);
        end

        // Build a full hart0 FIFO behind a busy hart1 without dropping anything
        for (int k = 0; k < 40 && qsize(0) < DEPTH; k++) begin
            set_rand(0);
            set_rand(1);
            hart_valid = {safe_push(1), safe_push(0)};
            step();
        end
        for (int k = 0; k < 40 && qsize(1) > 0; k++) begin
            set_rand(0);
            hart_valid = {1'b0, safe_push(0)};
            step();
        end
        for (int k = 0; k < 8; k++) begin
            set_rand(0);
            hart_valid = 2'b01;
            step();
            chk("fwp_valid", dbg_valid, 1'b1);
            chk("fwp_drop0", drop_cnt[15:0], 16'd0);
        end

        // Reset while both FIFOs hold records and the output stage is busy
        hart_valid = 2'b00;
        repeat (6) step();
        for (int k = 0; k < 3; k++) begin
            set_rand(0);
            set_rand(1);
            hart_valid = 2'b11;
            step();
        end
        chk("pre_reset_valid", dbg_valid, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        hart_valid = 2'b00;
        chk("rst_mid_valid", dbg_valid, 1'b0);
        chk("rst_mid_drop", drop_cnt, 32'd0);
        chk("rst_mid_ovf", overflow, 2'b00);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rst_no_stale", dbg_valid, 1'b0);
        end

        // Overflow: both harts stream for 10 cycles
        for (int k = 0; k < 10; k++) begin
            set_rand(0);
            set_rand(1);
            hart_valid = 2'b11;
            step();
        end
        chk("ovf_flag1", overflow[1], 1'b1);
        chk("ovf_cnt1_nonzero", (drop_cnt[31:16] != 16'd0), 1'b1);

        // Keep streaming until the 2-bit counter of hart0 has saturated
        for (int k = 0; k < 14; k++) begin
            set_rand(0);
            set_rand(1);
            hart_valid = 2'b11;
            step();
        end
        chk("sat_hold3", s_drop_cnt[1:0], 2'd3);
        chk("wide_past3", (drop_cnt[15:0] > 16'd3), 1'b1);

        // Random traffic with a single reset pulse in the middle
        for (int k = 0; k < 200; k++) begin
            set_rand(0);
            set_rand(1);
            hart_valid[0] = ($urandom_range(0, 3) != 0);
            hart_valid[1] = ($urandom_range(0, 2) == 0);
            reset = (k == 100);
            step();
        end
        reset = 1'b0;
        hart_valid = 2'b00;
        repeat (12) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
